// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
// Optional madd/msub accumulate support is enabled by defining MDU_MADD_EN.
module mult_div_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            md_op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W       = DATA_WIDTH;
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [W-1:0]     ONE     = W'(1);
    localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [W-1:0]     pending_hi;
    logic [W-1:0]     pending_lo;

    logic [2*W-1:0]   prod_s;
    logic [2*W-1:0]   prod_u;
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [W-1:0]     dvd;
    logic [W-1:0]     dvs;
    logic [W-1:0]     quo;
    logic [W-1:0]     rem;
    logic [W-1:0]     res_hi;
    logic [W-1:0]     res_lo;
    logic             run_op;
    logic [CNT_W-1:0] run_cycles;

    // Result is fully formed at acceptance; RUN only models the latency.
    always_comb begin
        prod_s     = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
        prod_u     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        is_signed  = ~md_op[0];
        a_neg      = is_signed & a[W-1];
        b_neg      = is_signed & b[W-1];
        dvd        = a_neg ? (~a + ONE) : a;
        dvs        = b_neg ? (~b + ONE) : b;
        if (dvs == '0) begin
            dvs = ONE;
        end
        quo        = dvd / dvs;
        rem        = dvd % dvs;
        res_hi     = '0;
        res_lo     = '0;
        run_op     = 1'b0;
        run_cycles = '0;
        case (md_op)
            3'b000: begin
                {res_hi, res_lo} = prod_s;
                run_op           = 1'b1;
                run_cycles       = MULT_N;
            end
            3'b001: begin
                {res_hi, res_lo} = prod_u;
                run_op           = 1'b1;
                run_cycles       = MULT_N;
            end
            3'b010, 3'b011: begin
                run_op     = 1'b1;
                run_cycles = DIV_N;
                if (b == '0) begin
                    res_hi = a;
                    res_lo = '1;
                end else if (is_signed && a == MOST_NEG && b == '1) begin
                    res_hi = '0;
                    res_lo = a;
                end else begin
                    res_lo = (a_neg ^ b_neg) ? -quo : quo;
                    res_hi = a_neg ? -rem : rem;
                end
            end
`ifdef MDU_MADD_EN
            3'b110: begin
                {res_hi, res_lo} = {hi, lo} + prod_s;
                run_op           = 1'b1;
                run_cycles       = MULT_N;
            end
            3'b111: begin
                {res_hi, res_lo} = {hi, lo} - prod_s;
                run_op           = 1'b1;
                run_cycles       = MULT_N;
            end
`endif
            default: begin
                run_op = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            busy       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (run_op) begin
                            pending_hi <= res_hi;
                            pending_lo <= res_lo;
                            counter    <= run_cycles;
                            busy       <= 1'b1;
                            state      <= RUN;
                        end else if (md_op == 3'b100) begin
                            hi <= a;
                        end else if (md_op == 3'b101) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    if (counter == CNT_W'(1)) begin
                        hi      <= pending_hi;
                        lo      <= pending_lo;
                        counter <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;

    mult_div_unit #(
        .DATA_WIDTH (32),
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .md_op(md_op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        md_op = op;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input int exp_n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit inject);
        int n;
        issue(op, av, bv);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (inject && n == 1) begin
                start = 1'b1;
                md_op = OP_MTLO;
                a     = 32'h5555_5555;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(exp_n));
        check({tag, "_hi"}, {32'h0, hi}, {32'h0, exp_hi});
        check({tag, "_lo"}, {32'h0, lo}, {32'h0, exp_lo});
    endtask

    initial begin
        int seen_busy;
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'b000;
        a     = '0;
        b     = '0;
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_hi", {32'h0, hi}, 64'h0);
        check("reset_lo", {32'h0, lo}, 64'h0);

        seen_busy = 0;
        issue(OP_MTHI, 32'h1234_5678, 32'h0);
        seen_busy += busy;
        check("mthi_hi", {32'h0, hi}, 64'h1234_5678);
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
        seen_busy += busy;
        check("mtlo_lo", {32'h0, lo}, 64'h9ABC_DEF0);
        check("mtlo_hi_kept", {32'h0, hi}, 64'h1234_5678);
        check("mtx_busy", 64'(seen_busy), 64'h0);

        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFF, 32'h2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_negdivisor", OP_DIV, 32'h7, 32'hFFFF_FFFE, 10, 32'h1, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_zero", OP_DIVU, 32'h7, 32'h0, 10, 32'h7, 32'hFFFF_FFFF, 1'b0);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'h2, 10, 32'h1, 32'h7FFF_FFFC, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 1'b1);

        issue(OP_MULT, 32'd3, 32'd4);
        check("abort_busy_before", {63'h0, busy}, 64'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_hi", {32'h0, hi}, 64'h0);
        check("abort_lo", {32'h0, lo}, 64'h0);
        repeat (8) @(negedge clk);
        check("abort_no_commit", {hi, lo}, 64'h0);

        issue(OP_MTHI, 32'h0, 32'h0);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
`ifdef MDU_MADD_EN
        run_op("madd", OP_MADD, 32'h1, 32'h1, 5, 32'h1, 32'h0, 1'b0);
        run_op("msub", 3'b111, 32'h2, 32'h3, 5, 32'h0, 32'hFFFF_FFFA, 1'b0);
`else
        issue(OP_MADD, 32'h1, 32'h1);
        check("madd_off_busy", {63'h0, busy}, 64'h0);
        @(negedge clk);
        check("madd_off_busy2", {63'h0, busy}, 64'h0);
        check("madd_off_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage of the 5-stage MIPS pipeline alongside the ALU.
- Accepts one operation per start pulse and holds `busy` for a configurable latency. The D-stage hazard logic stalls any md-class instruction while `busy` or `start` is high.
- `hi`/`lo` are read combinationally by mfhi/mflo forwarding.
- Generalises the fixed-latency datapath to parametrised width and per-class latencies.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/msub when enabled); must be >= 1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe from the E stage, sampled on the rising edge.
- md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 msub.
- a  input  DATA_WIDTH  operand rs (forwarded value).
- b  input  DATA_WIDTH  operand rt (forwarded value).
- busy  output  1  high while a multi-cycle operation is in flight.
- hi  output  DATA_WIDTH  HI register.
- lo  output  DATA_WIDTH  LO register.

Behaviour:
- Reset: on a clock edge with reset=1, hi=0, lo=0, busy=0, state=IDLE, counter=0. This overrides any start in the same cycle and aborts any in-flight operation; the pending result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, cycle counter counting down.
- IDLE to RUN: on start=1 with md_op in {mult, multu, div, divu}, or {madd, msub} when enabled.
  - Operands are latched; the result is computed into pending_hi/pending_lo at acceptance.
  - counter loads MULT_CYCLES or DIV_CYCLES.
  - busy rises on the next cycle.
- RUN: counter decrements each cycle. On the edge where counter==1, hi/lo take the pending values, state returns to IDLE and busy falls.
- Latency: start at edge t gives busy=1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) and new hi/lo visible after edge t+N.
- mthi/mtlo: accepted only in IDLE. hi (or lo) is written with `a` at the same edge; busy stays 0.
- start while busy=1: ignored, with no effect on state, hi or lo. The pipeline guarantees this never happens; a bench may check it.
- mult: {hi,lo} = signed a × signed b, 2·DATA_WIDTH-bit product.
- multu: {hi,lo} = unsigned a × unsigned b.
- div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero (b==0): lo = all ones, hi = a. No trap.
- Signed overflow (a = most negative, b = −1): lo = a, hi = 0.
- hi/lo hold their values at all other times.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: md_op 110 (madd) computes {hi,lo} += signed a × b; md_op 111 (msub) computes {hi,lo} −= signed a × b. Both are modulo 2^(2·DATA_WIDTH) and use MULT_CYCLES latency. The accumulate base is the hi/lo value at the acceptance edge.
- Not defined: md_op 110/111 with start=1 are ignored (no state change, busy stays 0). No accumulate logic is synthesised.

Test Plan:
- reset=1 for 1 cycle, then mthi a=0x12345678, then mtlo a=0x9ABCDEF0 → hi=0x12345678 and lo=0x9ABCDEF0 one edge after each; busy never high.
- mult with a=0xFFFFFFFF (−1), b=0x00000002 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (−7), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=0 → lo=0xFFFFFFFF, hi=0x00000007.
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Pulse start with mtlo during busy → ignored, lo unchanged.
- mult 3×4 started, reset=1 asserted on the 3rd busy cycle → next edge busy=0, hi=0, lo=0; no late commit occurs afterwards.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, madd a=1, b=1 → hi=1, lo=0 after 5 cycles. Without MDU_MADD_EN: same stimulus → busy stays 0, hi/lo unchanged.
